// File: rtl/lane_wb_arbiter.sv
// Writeback arbiter for vector-lane functional units: round-robin between bursts,
// locks onto one unit for a whole burst, and feeds a single registered writeback port.
module lane_wb_arbiter #(
    parameter int NUM_REQ = 5,
    parameter int DATA_W  = 16,
    parameter int VREG_W  = 5,
    parameter int IDX_W   = 6,
    localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*VREG_W-1:0] req_vd,
    input  logic [NUM_REQ*IDX_W-1:0]  req_idx,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      wb_valid,
    output logic [VREG_W-1:0]         wb_vd,
    output logic [IDX_W-1:0]          wb_idx,
    output logic [DATA_W-1:0]         wb_data,
    output logic [SRC_W-1:0]          wb_src,
    input  logic                      wb_ready,
    output logic                      busy
);

    typedef enum logic {IDLE, LOCK} state_e;

    localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_REQ - 1);

    state_e             state_q, state_d;
    logic [SRC_W-1:0]   owner_q, owner_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               wb_valid_q;
    logic [VREG_W-1:0]  wb_vd_q;
    logic [IDX_W-1:0]   wb_idx_q;
    logic [DATA_W-1:0]  wb_data_q;
    logic [SRC_W-1:0]   wb_src_q;

    logic               accept;
    logic               found;
    logic               xfer;
    logic [SRC_W-1:0]   winner;
    logic [SRC_W-1:0]   grant;

    logic [VREG_W-1:0]  vd_arr   [NUM_REQ];
    logic [IDX_W-1:0]   idx_arr  [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign vd_arr[g]   = req_vd[g*VREG_W +: VREG_W];
        assign idx_arr[g]  = req_idx[g*IDX_W +: IDX_W];
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    assign accept = !wb_valid_q || wb_ready;

    // Rotating priority search starting at rr_ptr, wrapping at NUM_REQ.
    always_comb begin : winner_search
        logic [SRC_W:0]   sum;
        logic [SRC_W-1:0] cand;
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
            if (sum >= (SRC_W+1)'(NUM_REQ)) begin
                sum = sum - (SRC_W+1)'(NUM_REQ);
            end
            cand = sum[SRC_W-1:0];
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        req_ready = '0;
        grant     = winner;
        if (!RST) begin
            unique case (state_q)
                IDLE: begin
                    grant = winner;
                    if (found) begin
                        req_ready[winner] = accept;
                    end
                end
                LOCK: begin
                    grant = owner_q;
                    req_ready[owner_q] = accept & req_valid[owner_q];
                end
                default: ;
            endcase
        end
        xfer = |(req_valid & req_ready);
        // Burst end releases the lock and moves priority past the finishing unit.
        if (xfer) begin
            if (req_last[grant]) begin
                state_d  = IDLE;
                rr_ptr_d = (grant == LAST_SRC) ? '0 : grant + SRC_W'(1);
            end else begin
                state_d = LOCK;
                owner_d = grant;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Payload holds whenever nothing new is loaded; valid only clears on an idle accept.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wb_valid_q <= 1'b0;
            wb_vd_q    <= '0;
            wb_idx_q   <= '0;
            wb_data_q  <= '0;
            wb_src_q   <= '0;
        end else if (xfer) begin
            wb_valid_q <= 1'b1;
            wb_vd_q    <= vd_arr[grant];
            wb_idx_q   <= idx_arr[grant];
            wb_data_q  <= data_arr[grant];
            wb_src_q   <= grant;
        end else if (accept) begin
            wb_valid_q <= 1'b0;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_vd    = wb_vd_q;
    assign wb_idx   = wb_idx_q;
    assign wb_data  = wb_data_q;
    assign wb_src   = wb_src_q;
    assign busy     = (state_q == LOCK) || wb_valid_q;

endmodule

// File: tb/tb_lane_wb_arbiter.sv
// Directed bench for lane_wb_arbiter: reset, round-robin wrap, burst lock,
// backpressure, owner bubble and reset in the middle of a burst.
module tb_lane_wb_arbiter;

    logic        CLK;
    logic        RST;
    logic [4:0]  reqValid;
    logic [4:0]  reqLast;
    logic [24:0] reqVd;
    logic [29:0] reqIdx;
    logic [79:0] reqData;
    logic [4:0]  reqReady;
    logic        wbValid;
    logic [4:0]  wbVd;
    logic [5:0]  wbIdx;
    logic [15:0] wbData;
    logic [2:0]  wbSrc;
    logic        wbReady;
    logic        busy;

    int testsRun    = 0;
    int testsFailed = 0;

    lane_wb_arbiter dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (reqValid),
        .req_last  (reqLast),
        .req_vd    (reqVd),
        .req_idx   (reqIdx),
        .req_data  (reqData),
        .req_ready (reqReady),
        .wb_valid  (wbValid),
        .wb_vd     (wbVd),
        .wb_idx    (wbIdx),
        .wb_data   (wbData),
        .wb_src    (wbSrc),
        .wb_ready  (wbReady),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Unit u presents element n: vd = u+1, data = 0x1000*(u+1) + n.
    task automatic setUnit(input int u, input logic v, input logic l, input int n);
        reqValid[u]         = v;
        reqLast[u]          = l;
        reqVd[u*5 +: 5]     = 5'(u + 1);
        reqIdx[u*6 +: 6]    = 6'(n);
        reqData[u*16 +: 16] = 16'(16'h1000 * (u + 1) + n);
    endtask

    task automatic doReset;
        RST      = 1'b1;
        reqValid = '0;
        reqLast  = '0;
        reqVd    = '0;
        reqIdx   = '0;
        reqData  = '0;
        wbReady  = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset;
        doReset();
        RST = 1'b1;
        for (int u = 0; u < 5; u++) setUnit(u, 1'b1, 1'b1, 0);
        tick();
        tick();
        testsRun++; if (reqReady !== 5'b00000) begin testsFailed++; $display("[TB] FAIL reset_ready: got %b expected %b", reqReady, 5'b00000); end
        testsRun++; if (wbValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_wbvalid: got %b expected 0", wbValid); end
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        testsRun++; if (wbData !== 16'h0 || wbSrc !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_payload: got %h/%0d expected 0/0", wbData, wbSrc); end
        RST = 1'b0;
        #1;
        testsRun++; if (reqReady !== 5'b00001) begin testsFailed++; $display("[TB] FAIL reset_first_grant: got %b expected %b", reqReady, 5'b00001); end
        tick();
        testsRun++; if (wbValid !== 1'b1 || wbSrc !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_first_wb: got v=%b src=%0d expected v=1 src=0", wbValid, wbSrc); end
        testsRun++; if (wbData !== 16'h1000) begin testsFailed++; $display("[TB] FAIL reset_first_data: got %h expected 1000", wbData); end
    endtask

    task automatic test_round_robin;
        doReset();
        for (int u = 0; u < 5; u++) setUnit(u, 1'b1, 1'b1, 0);
        for (int c = 0; c < 6; c++) begin
            logic [4:0]  expReady;
            logic [15:0] expData;
            expReady = 5'(1 << (c % 5));
            expData  = 16'(16'h1000 * ((c % 5) + 1));
            #1;
            testsRun++; if (reqReady !== expReady) begin testsFailed++; $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", c, reqReady, expReady); end
            tick();
            testsRun++; if (wbValid !== 1'b1 || wbSrc !== 3'(c % 5)) begin testsFailed++; $display("[TB] FAIL rr_wb[%0d]: got v=%b src=%0d expected v=1 src=%0d", c, wbValid, wbSrc, c % 5); end
            testsRun++; if (wbData !== expData) begin testsFailed++; $display("[TB] FAIL rr_data[%0d]: got %h expected %h", c, wbData, expData); end
        end
    endtask

    task automatic test_burst_lock;
        doReset();
        setUnit(2, 1'b1, 1'b0, 0);
        #1;
        testsRun++; if (reqReady !== 5'b00100) begin testsFailed++; $display("[TB] FAIL burst_first_ready: got %b expected %b", reqReady, 5'b00100); end
        tick();
        setUnit(0, 1'b1, 1'b1, 0);
        for (int n = 1; n <= 3; n++) begin
            setUnit(2, 1'b1, (n == 3), n);
            #1;
            testsRun++; if (reqReady !== 5'b00100) begin testsFailed++; $display("[TB] FAIL burst_ready[%0d]: got %b expected %b", n, reqReady, 5'b00100); end
            testsRun++; if (wbValid !== 1'b1 || wbSrc !== 3'd2 || wbIdx !== 6'(n - 1)) begin testsFailed++; $display("[TB] FAIL burst_wb[%0d]: got v=%b src=%0d idx=%0d expected v=1 src=2 idx=%0d", n, wbValid, wbSrc, wbIdx, n - 1); end
            tick();
        end
        setUnit(2, 1'b0, 1'b0, 0);
        #1;
        testsRun++; if (wbSrc !== 3'd2 || wbIdx !== 6'd3) begin testsFailed++; $display("[TB] FAIL burst_last_wb: got src=%0d idx=%0d expected src=2 idx=3", wbSrc, wbIdx); end
        testsRun++; if (reqReady !== 5'b00001) begin testsFailed++; $display("[TB] FAIL burst_release_ready: got %b expected %b", reqReady, 5'b00001); end
        tick();
        testsRun++; if (wbValid !== 1'b1 || wbSrc !== 3'd0) begin testsFailed++; $display("[TB] FAIL burst_then_unit0: got v=%b src=%0d expected v=1 src=0", wbValid, wbSrc); end
    endtask

    task automatic test_rr_after_burst;
        doReset();
        setUnit(2, 1'b1, 1'b0, 0);
        tick();
        setUnit(2, 1'b1, 1'b1, 1);
        tick();
        setUnit(2, 1'b0, 1'b0, 0);
        setUnit(0, 1'b1, 1'b1, 0);
        setUnit(1, 1'b1, 1'b1, 0);
        setUnit(3, 1'b1, 1'b1, 0);
        setUnit(4, 1'b1, 1'b1, 0);
        #1;
        testsRun++; if (reqReady !== 5'b01000) begin testsFailed++; $display("[TB] FAIL rr_ptr_after_burst: got %b expected %b", reqReady, 5'b01000); end
    endtask

    task automatic test_backpressure;
        doReset();
        setUnit(1, 1'b1, 1'b1, 0);
        reqData[16 +: 16] = 16'h3C00;
        tick();
        wbReady = 1'b0;
        setUnit(1, 1'b1, 1'b1, 1);
        setUnit(3, 1'b1, 1'b1, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            testsRun++; if (reqReady !== 5'b00000) begin testsFailed++; $display("[TB] FAIL bp_ready[%0d]: got %b expected %b", c, reqReady, 5'b00000); end
            testsRun++; if (wbValid !== 1'b1 || wbData !== 16'h3C00 || wbSrc !== 3'd1 || wbIdx !== 6'd0) begin testsFailed++; $display("[TB] FAIL bp_hold[%0d]: got v=%b data=%h src=%0d idx=%0d expected v=1 data=3c00 src=1 idx=0", c, wbValid, wbData, wbSrc, wbIdx); end
            tick();
        end
        wbReady = 1'b1;
        #1;
        testsRun++; if (reqReady !== 5'b01000) begin testsFailed++; $display("[TB] FAIL bp_release_ready: got %b expected %b", reqReady, 5'b01000); end
        tick();
        testsRun++; if (wbValid !== 1'b1 || wbSrc !== 3'd3 || wbData !== 16'h4000) begin testsFailed++; $display("[TB] FAIL bp_no_bubble: got v=%b src=%0d data=%h expected v=1 src=3 data=4000", wbValid, wbSrc, wbData); end
    endtask

    task automatic test_owner_bubble;
        doReset();
        setUnit(3, 1'b1, 1'b0, 0);
        tick();
        setUnit(3, 1'b0, 1'b0, 1);
        setUnit(1, 1'b1, 1'b1, 0);
        for (int c = 0; c < 2; c++) begin
            #1;
            testsRun++; if (reqReady !== 5'b00000) begin testsFailed++; $display("[TB] FAIL bubble_ready[%0d]: got %b expected %b", c, reqReady, 5'b00000); end
            tick();
            testsRun++; if (wbValid !== 1'b0 || busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL bubble_state[%0d]: got v=%b busy=%b expected v=0 busy=1", c, wbValid, busy); end
        end
        setUnit(3, 1'b1, 1'b1, 1);
        #1;
        testsRun++; if (reqReady !== 5'b01000) begin testsFailed++; $display("[TB] FAIL bubble_resume_ready: got %b expected %b", reqReady, 5'b01000); end
        tick();
        testsRun++; if (wbValid !== 1'b1 || wbSrc !== 3'd3 || wbIdx !== 6'd1) begin testsFailed++; $display("[TB] FAIL bubble_resume_wb: got v=%b src=%0d idx=%0d expected v=1 src=3 idx=1", wbValid, wbSrc, wbIdx); end
        setUnit(3, 1'b0, 1'b0, 0);
        #1;
        testsRun++; if (reqReady !== 5'b00010) begin testsFailed++; $display("[TB] FAIL bubble_next_ready: got %b expected %b", reqReady, 5'b00010); end
        tick();
        testsRun++; if (wbValid !== 1'b1 || wbSrc !== 3'd1) begin testsFailed++; $display("[TB] FAIL bubble_next_wb: got v=%b src=%0d expected v=1 src=1", wbValid, wbSrc); end
    endtask

    task automatic test_reset_mid_burst;
        doReset();
        setUnit(4, 1'b1, 1'b0, 0);
        tick();
        setUnit(4, 1'b1, 1'b0, 1);
        tick();
        setUnit(4, 1'b1, 1'b0, 2);
        setUnit(0, 1'b1, 1'b1, 0);
        RST = 1'b1;
        #1;
        testsRun++; if (wbValid !== 1'b0 || busy !== 1'b0 || reqReady !== 5'b00000) begin testsFailed++; $display("[TB] FAIL midrst_state: got v=%b busy=%b ready=%b expected v=0 busy=0 ready=00000", wbValid, busy, reqReady); end
        testsRun++; if (wbData !== 16'h0 || wbSrc !== 3'd0) begin testsFailed++; $display("[TB] FAIL midrst_payload: got %h/%0d expected 0/0", wbData, wbSrc); end
        tick();
        RST = 1'b0;
        #1;
        testsRun++; if (reqReady !== 5'b00001) begin testsFailed++; $display("[TB] FAIL midrst_first_ready: got %b expected %b", reqReady, 5'b00001); end
        tick();
        setUnit(0, 1'b0, 1'b0, 0);
        #1;
        testsRun++; if (wbValid !== 1'b1 || wbSrc !== 3'd0) begin testsFailed++; $display("[TB] FAIL midrst_first_wb: got v=%b src=%0d expected v=1 src=0", wbValid, wbSrc); end
        testsRun++; if (reqReady !== 5'b10000) begin testsFailed++; $display("[TB] FAIL midrst_then_unit4: got %b expected %b", reqReady, 5'b10000); end
    endtask

    initial begin
        RST      = 1'b1;
        reqValid = '0;
        reqLast  = '0;
        reqVd    = '0;
        reqIdx   = '0;
        reqData  = '0;
        wbReady  = 1'b1;
        test_reset();
        test_round_robin();
        test_burst_lock();
        test_rr_after_burst();
        test_backpressure();
        test_owner_bubble();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/lane_wb_arbiter.md
LANE_WB_ARBITER -- requirements
Module: lane_wb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 5, meaning functional-unit requesters: index 0 ALU, 1 EXP, 2 SQRT, 3 MUL, 4 DIV.
REQ-002 Parameter DATA_W, default 16, meaning element width in bits.
REQ-003 Parameter VREG_W, default 5, meaning destination vector register index width.
REQ-004 Parameter IDX_W, default 6, meaning element index width within vd.
REQ-005 Derived SRC_W = max(1, clog2(NUM_REQ)).
REQ-006 CLK  input  1  sole clock, all state on rising edge.
REQ-007 RST  input  1  asynchronous, active-high reset.
REQ-008 req_valid  input  NUM_REQ  per-unit result valid.
REQ-009 req_last  input  NUM_REQ  per-unit: this element ends the unit's burst.
REQ-010 req_vd  input  NUM_REQ*VREG_W  per-unit destination register.
REQ-011 req_idx  input  NUM_REQ*IDX_W  per-unit element index.
REQ-012 req_data  input  NUM_REQ*DATA_W  per-unit result.
REQ-013 req_ready  output  NUM_REQ  per-unit grant; transfer = req_valid[i] & req_ready[i].
REQ-014 wb_valid  output  1  writeback register holds an element.
REQ-015 wb_vd / wb_idx / wb_data  output  VREG_W / IDX_W / DATA_W  registered writeback payload.
REQ-016 wb_src  output  SRC_W  index of the unit that produced the wb payload.
REQ-017 wb_ready  input  1  register file accepts wb payload this cycle.
REQ-018 busy  output  1  high when state is LOCK or wb_valid is high.

Function
REQ-019 accept = !wb_valid | wb_ready, combinational; no transfer occurs in a cycle with accept low.
REQ-020 At most one req_ready bit is high per cycle; req_ready is all-zero when accept is low.
REQ-021 FSM states IDLE and LOCK; state register plus owner (SRC_W) and rr_ptr (SRC_W).
REQ-022 IDLE: winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... and wrapping NUM_REQ-1 to 0; req_ready[winner]=accept.
REQ-023 IDLE transfer with req_last[winner]=1: stay IDLE; rr_ptr <= (winner+1) mod NUM_REQ.
REQ-024 IDLE transfer with req_last[winner]=0: go to LOCK; owner <= winner; rr_ptr unchanged.
REQ-025 LOCK: only owner eligible; req_ready[owner]=accept & req_valid[owner]; all other req_ready are 0, even when the owner is idle (bubble).
REQ-026 LOCK transfer with req_last[owner]=1: go to IDLE; rr_ptr <= (owner+1) mod NUM_REQ.
REQ-027 On any transfer, the next edge loads wb_vd/wb_idx/wb_data/wb_src from the granted unit and sets wb_valid=1. Latency is exactly 1 cycle.
REQ-028 If accept is high and no transfer occurs, the next edge sets wb_valid=0; the payload registers hold their old values.
REQ-029 While wb_valid=1 and wb_ready=0, all wb_* outputs hold stable.
REQ-030 A drain (wb_ready=1) and a new load in the same cycle give back-to-back wb_valid with no bubble. Full throughput is 1 element per cycle.
REQ-031 req_ready may depend combinationally on req_valid. Requesters shall not make req_valid depend on req_ready.
REQ-032 No requester waits more than NUM_REQ-1 other bursts once its req_valid is held high in IDLE.

Reset
REQ-033 While RST=1: state=IDLE, owner=0, rr_ptr=0, wb_valid=0, wb_vd/wb_idx/wb_data/wb_src=0, busy=0, req_ready=0.
REQ-034 RST during LOCK or with wb_valid=1 discards the burst and the pending payload; first grant after release follows rr_ptr=0.

Verification
REQ-035 Reset: RST=1 with all req_valid=1 -> req_ready=0, wb_valid=0; after RST falls, unit 0 is granted first, wb_src=0 one cycle later.
REQ-036 Round-robin wrap: all 5 valid, req_last=1, wb_ready=1 for 6 cycles -> grants 0,1,2,3,4,0; wb_src repeats that sequence one cycle later; wb_valid continuous.
REQ-037 Burst lock: unit 2 sends idx 0..3 (req_last only on idx 3) while unit 0 stays valid -> wb_src=2,2,2,2 then 0; rr_ptr=3 after the burst.
REQ-038 Backpressure: wb_valid=1 with wb_data=0x3C00, wb_ready=0 for 3 cycles -> payload stable, req_ready=0; wb_ready=1 -> a new grant in that same cycle, no bubble.
REQ-039 Owner bubble: in LOCK, owner=3 drops req_valid for 2 cycles while unit 1 is valid -> unit 1 is not granted, wb_valid=0 after drain, busy=1; owner resumes and completes.
REQ-040 Reset mid-burst: RST pulses after 2 of 4 elements of unit 4 -> state IDLE, wb_valid=0; after release, unit 0 is granted (if valid) before unit 4.
